cdm_seq_mult: RTL and testbench

- Parametrised, iterative carry-disregard approximate multiplier with a valid/ready handshake on both sides.
- Successor to the fixed 16-bit combinational CDM cores: width is a parameter and the disregard depth k is chosen per transaction at run time; k = 0 gives an exact product.
- Processes one partial product per cycle; sits between operand FIFOs and the error-analysis datapath.

---
 rtl/cdm_seq_mult.sv | 215 +++++++++++++++++++++
 tb/tb_cdm_seq_mult.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cdm_seq_mult.sv
// -----------------------------------------------------------------------------
// cdm_seq_mult
//
// Iterative carry-disregard approximate multiplier. One partial product
// pp_i = (B[i] ? A : 0) << i is folded in per clock. The kc = min(k, 2W) low
// result columns are XOR-reduced (their carries are dropped), while the
// remaining high columns are summed exactly. k = 0 gives the exact product.
//
// Optional build macro: CDM_EXACT_CMP_EN
//   When defined, the block also accumulates the exact product in parallel and
//   presents P_exact (= A*B) and err_dist (= P_exact - R) alongside R.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    operand beat valid
//   in_ready   out  1    block accepts an operand beat (IDLE only)
//   A          in   W    multiplicand, unsigned
//   B          in   W    multiplier, unsigned
//   k          in   KW   number of low columns whose carries are disregarded
//   out_valid  out  1    result valid (DONE only)
//   out_ready  in   1    downstream accepts the result
//   R          out  2W   approximate product
//   P_exact    out  2W   exact product            (CDM_EXACT_CMP_EN only)
//   err_dist   out  2W   P_exact - R, never < 0   (CDM_EXACT_CMP_EN only)
//
// Timing: out_valid rises W edges after the accept edge; with out_ready held
// high one result is produced every W+2 cycles.
// -----------------------------------------------------------------------------
module cdm_seq_mult #(
   parameter int W  = 16,   // operand width, 4..32
   parameter int KW = 6     // k port width, 2**KW > 2*W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    A,
   input  logic [W-1:0]    B,
   input  logic [KW-1:0]   k,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*W-1:0]  R
`ifdef CDM_EXACT_CMP_EN
   ,
   output logic [2*W-1:0]  P_exact,
   output logic [2*W-1:0]  err_dist
`endif
);

   localparam int PW = 2 * W;
   localparam int IW = $clog2(W);

   localparam logic [KW-1:0] KC_MAX   = KW'(PW);
   localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;

   logic            accept;
   logic            last_pp;

   // Operands are kept pre-shifted: a_sh always holds A << i and b_sh[0] is
   // B[i], so no barrel shifter is needed to form the current partial product.
   logic [PW-1:0]   a_sh;
   logic [W-1:0]    b_sh;
   logic [KW-1:0]   kc_q;
   logic [IW-1:0]   idx;

   logic [PW-1:0]   hi_acc;
   logic [PW-1:0]   lo_acc;

   logic [KW-1:0]   kc_in;
   logic [PW-1:0]   lo_mask;
   logic [PW-1:0]   hi_mask;
   logic [PW-1:0]   pp;
   logic [PW-1:0]   hi_nxt;
   logic [PW-1:0]   lo_nxt;
   logic [PW-1:0]   r_nxt;

`ifdef CDM_EXACT_CMP_EN
   logic [PW-1:0]   ex_acc;
   logic [PW-1:0]   ex_nxt;
`endif

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // -------------------------------------------------------------------------
   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (last_pp) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Column split and per-cycle partial product
   // -------------------------------------------------------------------------
   // k beyond 2W would address columns that do not exist; clamp so the whole
   // result becomes XOR-only.
   assign kc_in = (k > KC_MAX) ? KC_MAX : k;

   // Shifting all-ones left by kc_q == 2W yields zero, so lo_mask becomes
   // all-ones exactly at the clamp point.
   assign lo_mask = ~({PW{1'b1}} << kc_q);
   assign hi_mask = ~lo_mask;

   assign pp      = b_sh[0] ? a_sh : '0;
   assign last_pp = (idx == IDX_LAST);

   assign hi_nxt  = hi_acc + (pp & hi_mask);
   assign lo_nxt  = lo_acc ^ (pp & lo_mask);

   // LO and HI occupy disjoint columns, so this add never carries from LO
   // into HI; it simply merges the two halves.
   assign r_nxt   = hi_nxt + lo_nxt;

`ifdef CDM_EXACT_CMP_EN
   assign ex_nxt  = ex_acc + pp;
`endif

   // -------------------------------------------------------------------------
   // Datapath
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         kc_q     <= '0;
         idx      <= '0;
         hi_acc   <= '0;
         lo_acc   <= '0;
         R        <= '0;
`ifdef CDM_EXACT_CMP_EN
         ex_acc   <= '0;
         P_exact  <= '0;
         err_dist <= '0;
`endif
      end else if (accept) begin
         a_sh     <= {{W{1'b0}}, A};
         b_sh     <= B;
         kc_q     <= kc_in;
         idx      <= '0;
         hi_acc   <= '0;
         lo_acc   <= '0;
`ifdef CDM_EXACT_CMP_EN
         ex_acc   <= '0;
`endif
      end else if (state_q == CALC) begin
         a_sh     <= a_sh << 1;
         b_sh     <= b_sh >> 1;
         idx      <= idx + IW'(1);
         hi_acc   <= hi_nxt;
         lo_acc   <= lo_nxt;
`ifdef CDM_EXACT_CMP_EN
         ex_acc   <= ex_nxt;
`endif
         // The final partial product is folded straight into the result so
         // R is ready on the same edge that enters DONE.
         if (last_pp) begin
            R        <= r_nxt;
`ifdef CDM_EXACT_CMP_EN
            P_exact  <= ex_nxt;
            err_dist <= ex_nxt - r_nxt;
`endif
         end
      end
   end

endmodule

// File: tb/tb_cdm_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_cdm_seq_mult
//
// Self-checking bench for cdm_seq_mult (W=16, KW=6). Expected results come
// from a column-level reference model of the carry-disregard product. Inputs
// are driven and outputs sampled on the falling clock edge.
// Build with +define+CDM_EXACT_CMP_EN to also check P_exact and err_dist.
// -----------------------------------------------------------------------------
module tb_cdm_seq_mult;

   localparam int W  = 16;
   localparam int KW = 6;
   localparam int PW = 2 * W;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    a_in = '0;
   logic [W-1:0]    b_in = '0;
   logic [KW-1:0]   k_in = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [PW-1:0]   r;
`ifdef CDM_EXACT_CMP_EN
   logic [PW-1:0]   p_exact;
   logic [PW-1:0]   err_dist;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   cdm_seq_mult #(.W(W), .KW(KW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a_in),
      .B         (b_in),
      .k         (k_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .R         (r)
`ifdef CDM_EXACT_CMP_EN
      ,
      .P_exact   (p_exact),
      .err_dist  (err_dist)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: split the 2W columns at kc, sum partial products exactly in
   // the high columns, XOR them in the low columns, truncate to 2W bits.
   function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input int kk);
      logic [63:0] lo_m, hi_sum, lo_x, p;
      int kc;
      kc     = (kk > PW) ? PW : kk;
      lo_m   = (64'd1 << kc) - 64'd1;
      hi_sum = '0;
      lo_x   = '0;
      for (int i = 0; i < W; i++) begin
         p      = b[i] ? (64'(a) << i) : 64'd0;
         hi_sum = hi_sum + (p & ~lo_m);
         lo_x   = lo_x ^ (p & lo_m);
      end
      return (hi_sum + lo_x) & ((64'd1 << PW) - 64'd1);
   endfunction

   // One complete transaction: accept, latency check, optional back-pressure,
   // result checks, handshake out.
   task automatic run_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [KW-1:0] kk, input int stall);
      logic [63:0] exp_r, exact;
      int waited, lat;
      exp_r  = model(a, b, int'(kk));
      exact  = 64'(a) * 64'(b);
      waited = 0;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("in_ready_idle", 64'(in_ready), 64'd1);
      a_in = a; b_in = b; k_in = kk;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check("in_ready_calc", 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 4 * W) begin
         // Operand inputs must be ignored after the accept edge.
         a_in = W'($urandom); b_in = W'($urandom); k_in = KW'($urandom);
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(W));
      check("out_valid", 64'(out_valid), 64'd1);
      check("R", 64'(r), exp_r);
      check("R_le_AxB", 64'(64'(r) <= exact), 64'd1);
`ifdef CDM_EXACT_CMP_EN
      check("P_exact", 64'(p_exact), exact);
      check("err_dist", 64'(err_dist), exact - exp_r);
`endif
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_R", 64'(r), exp_r);
         check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_valid", 64'(out_valid), 64'd0);
      check("post_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      int first_hit, second_hit, cyc;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_R", 64'(r), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_beat(16'd3, 16'd3, 6'd0, 0);
      check("dir_3x3_k0", 64'(r), 64'd9);
      run_beat(16'd3, 16'd3, 6'd2, 0);
      check("dir_3x3_k2", 64'(r), 64'd5);
      run_beat(16'hFFFF, 16'hFFFF, 6'd0, 0);
      check("dir_ffff_k0", 64'(r), 64'hFFFE0001);
      run_beat(16'hFFFF, 16'hFFFF, 6'd40, 0);
      run_beat(16'hFFFF, 16'hFFFF, 6'd32, 0);
      run_beat(16'd0, 16'hBEEF, 6'd7, 0);
      run_beat(16'h1234, 16'd0, 6'd33, 0);

      // Back-pressure: result held for 10 cycles
      run_beat(16'hA5C3, 16'h3C5A, 6'd12, 10);

      // Throughput with out_ready and in_valid held high: W+2 cycles/result
      a_in = 16'd1234; b_in = 16'd4321; k_in = 6'd9;
      in_valid = 1'b1; out_ready = 1'b1;
      first_hit = -1; second_hit = -1;
      for (cyc = 0; cyc < 10 * W && second_hit < 0; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            check("tput_R", 64'(r), model(16'd1234, 16'd4321, 9));
            if (first_hit < 0) first_hit = cyc;
            else second_hit = cyc;
         end
      end
      check("throughput", 64'(second_hit - first_hit), 64'(W + 2));
      in_valid = 1'b0; out_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset asserted mid-CALC aborts the transaction
      a_in = 16'hFFFF; b_in = 16'hFFFF; k_in = 6'd0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_R", 64'(r), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 2) begin
         @(negedge clk);
         check("abort_no_result", 64'(out_valid), 64'd0);
      end
      run_beat(16'd7, 16'd6, 6'd0, 0);
      check("after_abort_7x6", 64'(r), 64'd42);

      // Random soak with random back-pressure
      for (int n = 0; n < 2000; n++) begin
         run_beat(W'($urandom), W'($urandom), KW'($urandom_range(0, 33)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
